// File: rtl/lfcc_duty_ramp.sv
// lfcc_duty_ramp
// Soft-start / slew-limited duty-command stage for the 3-level FCC PWM generator.
// Moves o_duty_cmd toward a clamped duty target by STEP counts once every
// TICKS_PER_STEP PWM periods. It also provides a latched fault shutdown and a
// controlled ramp-down on disable. All outputs are registered.
module lfcc_duty_ramp #(
    parameter int N_MAX          = 78,
    parameter int DUTY_MIN       = 1,
    parameter int STEP           = 1,
    parameter int TICKS_PER_STEP = 4
) (
    input  logic       i_clk_pwm,
    input  logic       i_reset,
    input  logic       i_period_tick,
    input  logic       i_enable,
    input  logic [6:0] i_duty_target,
    input  logic       i_fault,
    input  logic       i_fault_clr,
    output logic [6:0] o_duty_cmd,
    output logic       o_gate_en,
    output logic       o_ramp_done,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRACK = 3'd1,
        S_HOLD  = 3'd2,
        S_RDOWN = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam int              CNT_W    = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);
    localparam logic [7:0]      MIN8     = 8'(DUTY_MIN);
    localparam logic [7:0]      MAX8     = 8'(N_MAX);
    localparam logic [7:0]      STEP8    = 8'(STEP);

    // Upward step that stops exactly at the limit instead of overshooting.
    function automatic logic [7:0] step_up(input logic [7:0] duty, input logic [7:0] lim);
        logic [7:0] sum;
        sum = duty + STEP8;
        return (sum > lim) ? lim : sum;
    endfunction

    // Downward step that stops exactly at the limit; the compare is done before
    // subtracting so the 8-bit value can never wrap below zero.
    function automatic logic [7:0] step_down(input logic [7:0] duty, input logic [7:0] lim);
        if (duty < lim + STEP8)
            return lim;
        else
            return duty - STEP8;
    endfunction

    state_t           r_state;
    logic [6:0]       r_duty;
    logic             r_gate_en;
    logic             r_ramp_done;
    logic [CNT_W-1:0] r_step_cnt;

    logic [7:0] w_tgt;
    logic [7:0] w_duty8;
    logic [7:0] w_track_next;
    logic [7:0] w_rdown_next;
    logic       w_step;

    // Clamp the software target into the legal DUTY_MIN..N_MAX command range.
    always_comb begin
        w_tgt = {1'b0, i_duty_target};
        if ({1'b0, i_duty_target} < MIN8)
            w_tgt = MIN8;
        else if ({1'b0, i_duty_target} > MAX8)
            w_tgt = MAX8;
    end

    assign w_duty8      = {1'b0, r_duty};
    assign w_step       = i_period_tick && (r_step_cnt == CNT_LAST);
    assign w_track_next = (w_duty8 < w_tgt) ? step_up(w_duty8, w_tgt) : step_down(w_duty8, w_tgt);
    assign w_rdown_next = step_down(w_duty8, MIN8);

    // Ramp prescaler: counts PWM periods while the converter is running.
    always_ff @(posedge i_clk_pwm) begin
        if (i_reset) begin
            r_step_cnt <= '0;
        end else if (r_state == S_IDLE || r_state == S_FAULT) begin
            r_step_cnt <= '0;
        end else if (i_period_tick) begin
            r_step_cnt <= (r_step_cnt == CNT_LAST) ? '0 : r_step_cnt + 1'b1;
        end
    end

    // Control FSM with registered duty, gate enable and ramp-done outputs.
    always_ff @(posedge i_clk_pwm) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_duty      <= MIN8[6:0];
            r_gate_en   <= 1'b0;
            r_ramp_done <= 1'b0;
        end else if (i_fault) begin
            // Fault overrides everything except reset, from any state.
            r_state     <= S_FAULT;
            r_duty      <= MIN8[6:0];
            r_gate_en   <= 1'b0;
            r_ramp_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_duty      <= MIN8[6:0];
                    r_ramp_done <= 1'b0;
                    if (i_enable) begin
                        r_state   <= S_TRACK;
                        r_gate_en <= 1'b1;
                    end
                end
                S_TRACK: begin
                    if (!i_enable) begin
                        r_state <= S_RDOWN;
                    end else if (w_step) begin
                        r_duty <= w_track_next[6:0];
                        if (w_track_next == w_tgt) begin
                            r_state     <= S_HOLD;
                            r_ramp_done <= 1'b1;
                        end
                    end else if (w_duty8 == w_tgt) begin
                        r_state     <= S_HOLD;
                        r_ramp_done <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!i_enable) begin
                        r_state     <= S_RDOWN;
                        r_ramp_done <= 1'b0;
                    end else if (w_tgt != w_duty8) begin
                        r_state     <= S_TRACK;
                        r_ramp_done <= 1'b0;
                    end
                end
                S_RDOWN: begin
                    if (i_enable) begin
                        // Resume from wherever the ramp-down got to.
                        r_state <= S_TRACK;
                    end else if (w_step) begin
                        r_duty <= w_rdown_next[6:0];
                        if (w_rdown_next == MIN8) begin
                            r_state   <= S_IDLE;
                            r_gate_en <= 1'b0;
                        end
                    end
                end
                S_FAULT: begin
                    r_duty      <= MIN8[6:0];
                    r_gate_en   <= 1'b0;
                    r_ramp_done <= 1'b0;
                    // Leave only once the cause is gone and the converter is disabled.
                    if (i_fault_clr && !i_enable)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_duty      <= MIN8[6:0];
                    r_gate_en   <= 1'b0;
                    r_ramp_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_duty_cmd  = r_duty;
    assign o_gate_en   = r_gate_en;
    assign o_ramp_done = r_ramp_done;
    assign o_state     = r_state;

endmodule

// File: tb/tb_lfcc_duty_ramp.sv
// Directed testbench for lfcc_duty_ramp. Instance A uses default parameters,
// instance B uses STEP=7 to exercise truncated steps at both ends of the range.
module tb_lfcc_duty_ramp;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       en_a;
    logic       en_b;
    logic       fault;
    logic       fault_clr;
    logic       zero;
    logic [6:0] tgt_a;
    logic [6:0] tgt_b;

    logic [6:0] duty_a;
    logic       gate_a;
    logic       done_a;
    logic [2:0] state_a;
    logic [6:0] duty_b;
    logic       gate_b;
    logic       done_b;
    logic [2:0] state_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfcc_duty_ramp dut_a (
        .i_clk_pwm    (clk),
        .i_reset      (reset),
        .i_period_tick(tick),
        .i_enable     (en_a),
        .i_duty_target(tgt_a),
        .i_fault      (fault),
        .i_fault_clr  (fault_clr),
        .o_duty_cmd   (duty_a),
        .o_gate_en    (gate_a),
        .o_ramp_done  (done_a),
        .o_state      (state_a)
    );

    lfcc_duty_ramp #(.STEP(7)) dut_b (
        .i_clk_pwm    (clk),
        .i_reset      (reset),
        .i_period_tick(tick),
        .i_enable     (en_b),
        .i_duty_target(tgt_b),
        .i_fault      (zero),
        .i_fault_clr  (zero),
        .o_duty_cmd   (duty_b),
        .o_gate_en    (gate_b),
        .o_ramp_done  (done_b),
        .o_state      (state_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick1();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL reset state: got %0d expected 0", state_a); end
        n_checks++; if (duty_a !== 7'd1) begin n_fail++; $display("FAIL reset duty: got %0d expected 1", duty_a); end
        n_checks++; if (gate_a !== 1'b0) begin n_fail++; $display("FAIL reset gate_en: got %0d expected 0", gate_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset ramp_done: got %0d expected 0", done_a); end
        n_checks++; if (duty_b !== 7'd1) begin n_fail++; $display("FAIL reset duty_b: got %0d expected 1", duty_b); end
    endtask

    task automatic test_ramp_up();
        int exp;
        tgt_a = 7'd40;
        en_a  = 1'b1;
        cyc();
        n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL up start state: got %0d expected 1", state_a); end
        n_checks++; if (gate_a !== 1'b1) begin n_fail++; $display("FAIL up start gate_en: got %0d expected 1", gate_a); end
        n_checks++; if (duty_a !== 7'd1) begin n_fail++; $display("FAIL up start duty: got %0d expected 1", duty_a); end
        for (int t = 1; t <= 156; t++) begin
            tick1();
            exp = 1 + t / 4;
            n_checks++; if (duty_a !== 7'(exp)) begin n_fail++; $display("FAIL up duty tick %0d: got %0d expected %0d", t, duty_a, exp); end
            if (t == 155) begin
                n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL up state before end: got %0d expected 1", state_a); end
                n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL up ramp_done early: got %0d expected 0", done_a); end
            end
        end
        n_checks++; if (state_a !== 3'd2) begin n_fail++; $display("FAIL up end state: got %0d expected 2", state_a); end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL up end ramp_done: got %0d expected 1", done_a); end
    endtask

    task automatic test_step7();
        int exp_up[3];
        int exp_dn[3];
        exp_up = '{8, 15, 20};
        exp_dn = '{13, 6, 1};
        tgt_b = 7'd20;
        en_b  = 1'b1;
        cyc();
        n_checks++; if (state_b !== 3'd1) begin n_fail++; $display("FAIL step7 start state: got %0d expected 1", state_b); end
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick1();
            n_checks++; if (duty_b !== 7'(exp_up[k])) begin n_fail++; $display("FAIL step7 up duty step %0d: got %0d expected %0d", k, duty_b, exp_up[k]); end
            n_checks++; if (done_b !== (k == 2)) begin n_fail++; $display("FAIL step7 up ramp_done step %0d: got %0d expected %0d", k, done_b, k == 2); end
        end
        n_checks++; if (state_b !== 3'd2) begin n_fail++; $display("FAIL step7 hold state: got %0d expected 2", state_b); end
        // Target 0 clamps to 1; the last down step must stop at 1, not wrap.
        tgt_b = 7'd0;
        cyc();
        n_checks++; if (state_b !== 3'd1) begin n_fail++; $display("FAIL step7 retrack state: got %0d expected 1", state_b); end
        n_checks++; if (done_b !== 1'b0) begin n_fail++; $display("FAIL step7 retrack ramp_done: got %0d expected 0", done_b); end
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick1();
            n_checks++; if (duty_b !== 7'(exp_dn[k])) begin n_fail++; $display("FAIL step7 down duty step %0d: got %0d expected %0d", k, duty_b, exp_dn[k]); end
        end
        n_checks++; if (state_b !== 3'd2) begin n_fail++; $display("FAIL step7 min hold state: got %0d expected 2", state_b); end
        n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL step7 min ramp_done: got %0d expected 1", done_b); end
        en_b = 1'b0;
        n_checks++; if (duty_a !== 7'd40 || state_a !== 3'd2) begin n_fail++; $display("FAIL idle A disturbed: got duty %0d state %0d expected 40 2", duty_a, state_a); end
    endtask

    task automatic test_clamp();
        int exp;
        tgt_a = 7'h7F;
        cyc();
        n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL clamp retrack state: got %0d expected 1", state_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL clamp ramp_done: got %0d expected 0", done_a); end
        for (int t = 1; t <= 152; t++) begin
            tick1();
            exp = 40 + t / 4;
            n_checks++; if (duty_a !== 7'(exp)) begin n_fail++; $display("FAIL clamp duty tick %0d: got %0d expected %0d", t, duty_a, exp); end
        end
        n_checks++; if (state_a !== 3'd2) begin n_fail++; $display("FAIL clamp hold state: got %0d expected 2", state_a); end
        n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL clamp ramp_done end: got %0d expected 1", done_a); end
        for (int t = 1; t <= 8; t++) begin
            tick1();
            n_checks++; if (duty_a !== 7'd78) begin n_fail++; $display("FAIL clamp overshoot tick %0d: got %0d expected 78", t, duty_a); end
        end
    endtask

    task automatic test_rampdown();
        int exp;
        tgt_a = 7'd40;
        cyc();
        for (int t = 1; t <= 152; t++) begin
            tick1();
            exp = 78 - t / 4;
            n_checks++; if (duty_a !== 7'(exp)) begin n_fail++; $display("FAIL retarget duty tick %0d: got %0d expected %0d", t, duty_a, exp); end
        end
        n_checks++; if (state_a !== 3'd2) begin n_fail++; $display("FAIL retarget hold state: got %0d expected 2", state_a); end
        en_a = 1'b0;
        cyc();
        n_checks++; if (state_a !== 3'd3) begin n_fail++; $display("FAIL rdown state: got %0d expected 3", state_a); end
        n_checks++; if (gate_a !== 1'b1) begin n_fail++; $display("FAIL rdown gate_en: got %0d expected 1", gate_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rdown ramp_done: got %0d expected 0", done_a); end
        for (int t = 1; t <= 156; t++) begin
            tick1();
            exp = 40 - t / 4;
            n_checks++; if (duty_a !== 7'(exp)) begin n_fail++; $display("FAIL rdown duty tick %0d: got %0d expected %0d", t, duty_a, exp); end
            if (t == 155) begin
                n_checks++; if (state_a !== 3'd3 || gate_a !== 1'b1) begin n_fail++; $display("FAIL rdown before end: got state %0d gate %0d expected 3 1", state_a, gate_a); end
            end
        end
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL rdown end state: got %0d expected 0", state_a); end
        n_checks++; if (gate_a !== 1'b0) begin n_fail++; $display("FAIL rdown end gate_en: got %0d expected 0", gate_a); end
        // Ramp to 30, start ramping down, re-enable at 25.
        tgt_a = 7'd30;
        en_a  = 1'b1;
        cyc();
        repeat (116) tick1();
        n_checks++; if (duty_a !== 7'd30 || state_a !== 3'd2) begin n_fail++; $display("FAIL reenable setup: got duty %0d state %0d expected 30 2", duty_a, state_a); end
        en_a = 1'b0;
        cyc();
        repeat (20) tick1();
        n_checks++; if (duty_a !== 7'd25 || state_a !== 3'd3) begin n_fail++; $display("FAIL partial rdown: got duty %0d state %0d expected 25 3", duty_a, state_a); end
        en_a  = 1'b1;
        tgt_a = 7'd40;
        cyc();
        n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL reenable state: got %0d expected 1", state_a); end
        n_checks++; if (duty_a !== 7'd25) begin n_fail++; $display("FAIL reenable duty jump: got %0d expected 25", duty_a); end
        repeat (4) tick1();
        n_checks++; if (duty_a !== 7'd26) begin n_fail++; $display("FAIL reenable upward: got %0d expected 26", duty_a); end
    endtask

    task automatic test_fault();
        fault = 1'b1;
        tick  = 1'b1;
        cyc();
        tick  = 1'b0;
        n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault state: got %0d expected 4", state_a); end
        n_checks++; if (gate_a !== 1'b0) begin n_fail++; $display("FAIL fault gate_en: got %0d expected 0", gate_a); end
        n_checks++; if (duty_a !== 7'd1) begin n_fail++; $display("FAIL fault duty: got %0d expected 1", duty_a); end
        // Clear request while the fault is still present must be ignored.
        fault_clr = 1'b1;
        en_a      = 1'b0;
        cyc();
        n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault clr while active: got %0d expected 4", state_a); end
        fault = 1'b0;
        en_a  = 1'b1;
        cyc();
        n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault clr enabled: got %0d expected 4", state_a); end
        fault_clr = 1'b0;
        en_a      = 1'b0;
        cyc();
        n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault latched: got %0d expected 4", state_a); end
        fault_clr = 1'b1;
        cyc();
        fault_clr = 1'b0;
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL fault exit state: got %0d expected 0", state_a); end
        n_checks++; if (gate_a !== 1'b0 || duty_a !== 7'd1) begin n_fail++; $display("FAIL fault exit outputs: got gate %0d duty %0d expected 0 1", gate_a, duty_a); end
    endtask

    task automatic test_reset_mid();
        tgt_a = 7'd40;
        en_a  = 1'b1;
        cyc();
        repeat (116) tick1();
        n_checks++; if (duty_a !== 7'd30 || state_a !== 3'd1) begin n_fail++; $display("FAIL midreset setup: got duty %0d state %0d expected 30 1", duty_a, state_a); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_checks++; if (duty_a !== 7'd1) begin n_fail++; $display("FAIL midreset duty: got %0d expected 1", duty_a); end
        n_checks++; if (gate_a !== 1'b0) begin n_fail++; $display("FAIL midreset gate_en: got %0d expected 0", gate_a); end
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL midreset state: got %0d expected 0", state_a); end
    endtask

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        en_a      = 1'b0;
        en_b      = 1'b0;
        fault     = 1'b0;
        fault_clr = 1'b0;
        zero      = 1'b0;
        tgt_a     = 7'd0;
        tgt_b     = 7'd0;
        test_reset();
        test_ramp_up();
        test_step7();
        test_clamp();
        test_rampdown();
        test_fault();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
